// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared widths, FSM states and constants for the LeNet output stage
//
// Purpose: common definitions used by fc_out_collect, its bank and its stream interface.
// Ports: none (package).
package lenet_pkg;

  localparam int DATA_W        = 16;  // width of one class score
  localparam int NUM_CLASS     = 10;  // scores per frame, fixed by the comparator tree
  localparam int CNT_W         = 4;   // slot counter / write index width
  localparam int GET_CLASS_LAT = 4;   // cycles from get_class start to done

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } state_t;

  // Flipping the sign bit maps two's complement onto offset binary, so an
  // unsigned comparison orders the scores the same way a signed one would.
  function automatic logic [DATA_W-1:0] to_offset_bin(input logic [DATA_W-1:0] d);
    return {~d[DATA_W-1], d[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/fc_out_collect_if.sv
// rtl/fc_out_collect_if.sv - serial score stream from the FC layer
//
// Purpose: groups the valid/ready score stream feeding fc_out_collect.
// Signals: fc_valid (beat valid), fc_first (beat is slot 0), fc_data (score),
//          fc_ready (collector accepts this cycle).
// Modports: master = FC layer side, slave = collector side.
interface fc_out_collect_if;
  import lenet_pkg::*;

  logic              fc_valid;
  logic              fc_first;
  logic [DATA_W-1:0] fc_data;
  logic              fc_ready;

  modport master (output fc_valid, output fc_first, output fc_data, input fc_ready);
  modport slave  (input fc_valid, input fc_first, input fc_data, output fc_ready);

endinterface

// File: rtl/fc_out_bank.sv
// rtl/fc_out_bank.sv - ten-entry score register bank
//
// Purpose: holds one frame of class scores; each entry keeps its value until rewritten.
// Ports: clk, rst (sync, active-high, clears all entries), wr_en, wr_idx (slot),
//        wr_data (score), bank (all entries, index = slot).
module fc_out_bank
  import lenet_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [CNT_W-1:0]                    wr_idx,
  input  logic [DATA_W-1:0]                   wr_data,
  output logic [NUM_CLASS-1:0][DATA_W-1:0]    bank
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (wr_en && (wr_idx == CNT_W'(i))) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/fc_out_collect.sv
// rtl/fc_out_collect.sv - collects ten FC scores and launches get_class
//
// Purpose: captures a serial frame of NUM_CLASS scores into a register bank,
//          pulses get_class_start once the bank is complete, then blocks new
//          beats until get_class_done.
// Ports: clk, rst (sync, active-high), fc (score stream, slave side),
//        class0..class9 (bank contents), get_class_start (one-cycle pulse),
//        get_class_done (completion from get_class), frame_err (sticky restart flag).
// Config: FC_OUT_OFFSET_EN - store scores as offset binary instead of raw.
module fc_out_collect
  import lenet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fc_out_collect_if.slave   fc,
  output logic [DATA_W-1:0] class0,
  output logic [DATA_W-1:0] class1,
  output logic [DATA_W-1:0] class2,
  output logic [DATA_W-1:0] class3,
  output logic [DATA_W-1:0] class4,
  output logic [DATA_W-1:0] class5,
  output logic [DATA_W-1:0] class6,
  output logic [DATA_W-1:0] class7,
  output logic [DATA_W-1:0] class8,
  output logic [DATA_W-1:0] class9,
  output logic              get_class_start,
  input  logic              get_class_done,
  output logic              frame_err
);

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt, cnt_nxt;
  logic [CNT_W-1:0]                 slot;
  logic                             accept;
  logic                             last_slot;
  logic [DATA_W-1:0]                wr_data;
  logic [NUM_CLASS-1:0][DATA_W-1:0] bank;

  // Acceptance is decoded from the state register directly so no input
  // reaches fc_ready combinationally.
  assign accept    = fc.fc_valid && (state == COLLECT);
  // fc_first forces slot 0 regardless of where the counter stands.
  assign slot      = fc.fc_first ? '0 : cnt;
  assign last_slot = (slot == CNT_W'(NUM_CLASS - 1));

`ifdef FC_OUT_OFFSET_EN
  assign wr_data = to_offset_bin(fc.fc_data);
`else
  assign wr_data = fc.fc_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    fc.fc_ready     = 1'b0;
    get_class_start = 1'b0;
    case (state)
      COLLECT: begin
        fc.fc_ready = 1'b1;
        if (accept && last_slot) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        get_class_start = 1'b1;
        state_nxt       = WAIT;
      end
      WAIT: begin
        if (get_class_done) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (accept) begin
      cnt_nxt = last_slot ? '0 : slot + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      // A new frame starting while a partial one is pending loses that frame.
      if (accept && fc.fc_first && (cnt != '0)) begin
        frame_err <= 1'b1;
      end
    end
  end

  fc_out_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (slot),
    .wr_data (wr_data),
    .bank    (bank)
  );

  assign class0 = bank[0];
  assign class1 = bank[1];
  assign class2 = bank[2];
  assign class3 = bank[3];
  assign class4 = bank[4];
  assign class5 = bank[5];
  assign class6 = bank[6];
  assign class7 = bank[7];
  assign class8 = bank[8];
  assign class9 = bank[9];

endmodule

// File: tb/tb_fc_out_collect.sv
// tb/tb_fc_out_collect.sv - scoreboard testbench for fc_out_collect
module tb_fc_out_collect;
  import lenet_pkg::*;

  typedef logic [NUM_CLASS-1:0][DATA_W-1:0] bank_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_out_collect_if fc_if ();

  logic [DATA_W-1:0] class0, class1, class2, class3, class4;
  logic [DATA_W-1:0] class5, class6, class7, class8, class9;
  logic              get_class_start;
  logic              get_class_done;
  logic              frame_err;
  logic              done_auto = 1'b0;
  logic              done_man  = 1'b0;

  assign get_class_done = done_auto | done_man;

  fc_out_collect dut (
    .clk             (clk),
    .rst             (rst),
    .fc              (fc_if),
    .class0          (class0),
    .class1          (class1),
    .class2          (class2),
    .class3          (class3),
    .class4          (class4),
    .class5          (class5),
    .class6          (class6),
    .class7          (class7),
    .class8          (class8),
    .class9          (class9),
    .get_class_start (get_class_start),
    .get_class_done  (get_class_done),
    .frame_err       (frame_err)
  );

  bank_t       exp_bank_q[$];
  logic        exp_err_q[$];
  int          exp_idx_q[$];
  string       chk_name_q[$];
  logic [31:0] chk_act_q[$];
  logic [31:0] chk_exp_q[$];

  int   checks  = 0;
  int   errors  = 0;
  int   n_start = 0;
  logic waiting    = 1'b0;
  logic prev_start = 1'b0;
  logic rst_q;

  always @(posedge clk) rst_q <= rst;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    bank_t act, e;
    logic  e_err;
    int    e_idx, amax;
    forever begin
      @(negedge clk);
      act = {class9, class8, class7, class6, class5, class4, class3, class2, class1, class0};
      if (rst_q === 1'b1) begin
        for (int i = 0; i < NUM_CLASS; i++) cmp($sformatf("rst_class%0d", i), 32'(act[i]), 32'h0);
        cmp("rst_start", 32'(get_class_start), 32'h0);
        cmp("rst_frame_err", 32'(frame_err), 32'h0);
        waiting    = 1'b0;
        prev_start = 1'b0;
      end else if (rst_q === 1'b0 && rst === 1'b0) begin
        cmp("fc_ready", 32'(fc_if.fc_ready), 32'(!(waiting || get_class_start)));
        if (get_class_start === 1'b1) begin
          cmp("start_width", 32'(prev_start), 32'h0);
          n_start++;
          if (exp_bank_q.size() == 0) begin
            cmp("unexpected_start", 32'(exp_bank_q.size()), 32'h1);
          end else begin
            e     = exp_bank_q.pop_front();
            e_err = exp_err_q.pop_front();
            e_idx = exp_idx_q.pop_front();
            for (int i = 0; i < NUM_CLASS; i++) cmp($sformatf("class%0d", i), 32'(act[i]), 32'(e[i]));
            cmp("start_frame_err", 32'(frame_err), 32'(e_err));
            if (e_idx >= 0) begin
              amax = 0;
              for (int i = 1; i < NUM_CLASS; i++) if (act[i] > act[amax]) amax = i;
              cmp("argmax", 32'(amax), 32'(e_idx));
            end
          end
          waiting = 1'b1;
        end else if (get_class_done === 1'b1 && waiting) begin
          waiting = 1'b0;
        end
        prev_start = get_class_start;
      end
      while (chk_name_q.size() > 0) begin
        cmp(chk_name_q.pop_front(), chk_act_q.pop_front(), chk_exp_q.pop_front());
      end
    end
  end

  // get_class model: done arrives GET_CLASS_LAT cycles after the start cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (get_class_start === 1'b1) begin
        repeat (GET_CLASS_LAT) @(posedge clk);
        #1 done_auto = 1'b1;
        @(posedge clk);
        #1 done_auto = 1'b0;
      end
    end
  end

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  task automatic push_exp(input bank_t b, input logic err, input int idx);
    exp_bank_q.push_back(b);
    exp_err_q.push_back(err);
    exp_idx_q.push_back(idx);
  endtask

  task automatic beat(input logic first, input logic [DATA_W-1:0] d);
    int n = 0;
    fc_if.fc_valid = 1'b1;
    fc_if.fc_first = first;
    fc_if.fc_data  = d;
    while (fc_if.fc_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) push_chk("ready_timeout", 32'(n), 32'h0);
    @(posedge clk);
    #1;
    fc_if.fc_valid = 1'b0;
    fc_if.fc_first = 1'b0;
  endtask

  task automatic send_frame(input bank_t d);
    for (int i = 0; i < NUM_CLASS; i++) beat(i == 0, d[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fc_if.fc_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 50) push_chk("idle_timeout", 32'(n), 32'h0);
  endtask

  function automatic bank_t ramp(input int base);
    bank_t b;
    for (int i = 0; i < NUM_CLASS; i++) b[i] = DATA_W'(base + i);
    return b;
  endfunction

  initial begin
    bank_t f, raw, ex;
    int    s0;
    fc_if.fc_valid = 1'b0;
    fc_if.fc_first = 1'b0;
    fc_if.fc_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1: 0x10..0x19, then hold 0xDEAD through ISSUE/WAIT.
    s0 = n_start;
    push_exp(ramp(16'h0010), 1'b0, -1);
    send_frame(ramp(16'h0010));
    fc_if.fc_valid = 1'b1;
    fc_if.fc_first = 1'b1;
    fc_if.fc_data  = 16'hDEAD;
    repeat (5) begin
      @(posedge clk);
      #1;
      push_chk("hold_class0", 32'(class0), 32'h0010);
      push_chk("hold_class9", 32'(class9), 32'h0019);
    end
    // Frame 2: the held 0xDEAD lands in slot 0 once ready returns.
    f = ramp(16'h0020);
    f[0] = 16'hDEAD;
    push_exp(f, 1'b0, -1);
    send_frame(f);
    wait_idle();
    push_chk("starts_t12", 32'(n_start - s0), 32'd2);

    // Restart after six beats.
    s0 = n_start;
    for (int i = 0; i < 6; i++) beat(i == 0, DATA_W'(16'h0030 + i));
    push_exp(ramp(16'h0100), 1'b1, -1);
    send_frame(ramp(16'h0100));
    wait_idle();
    push_chk("starts_t3", 32'(n_start - s0), 32'd1);
    push_chk("frame_err_t3", 32'(frame_err), 32'h1);

    // Signed scores; stored form depends on the offset option.
    s0 = n_start;
    raw = '0;
    raw[1] = 16'h0001;
    raw[3] = 16'hFFFB;
    raw[5] = 16'hFFFF;
    raw[7] = 16'h0002;
`ifdef FC_OUT_OFFSET_EN
    for (int i = 0; i < NUM_CLASS; i++) ex[i] = 16'h8000;
    ex[1] = 16'h8001;
    ex[3] = 16'h7FFB;
    ex[5] = 16'h7FFF;
    ex[7] = 16'h8002;
    push_exp(ex, 1'b1, 7);
`else
    ex = raw;
    push_exp(ex, 1'b1, 5);
`endif
    send_frame(raw);
    wait_idle();
    push_chk("starts_t4", 32'(n_start - s0), 32'd1);

    // Reset mid-frame, then a full frame.
    s0 = n_start;
    for (int i = 0; i < 4; i++) beat(i == 0, DATA_W'(16'h0040 + i));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push_chk("frame_err_after_rst", 32'(frame_err), 32'h0);
    push_exp(ramp(16'h0050), 1'b0, -1);
    send_frame(ramp(16'h0050));
    wait_idle();
    push_chk("starts_t5", 32'(n_start - s0), 32'd1);

    // Spurious done while collecting.
    s0 = n_start;
    f = ramp(16'h0060);
    push_exp(f, 1'b0, -1);
    for (int i = 0; i < 3; i++) beat(i == 0, f[i]);
    done_man = 1'b1;
    @(posedge clk);
    #1 done_man = 1'b0;
    @(posedge clk);
    #1;
    push_chk("starts_after_done", 32'(n_start - s0), 32'd0);
    for (int i = 3; i < NUM_CLASS; i++) beat(1'b0, f[i]);
    wait_idle();
    push_chk("starts_t6", 32'(n_start - s0), 32'd1);
    push_chk("frame_err_t6", 32'(frame_err), 32'h0);

    repeat (5) @(posedge clk);
    #1 push_chk("frames_left", 32'(exp_bank_q.size()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
